// File: rtl/uart_pkg.sv
// uart_pkg -- definitions shared by the bridge's UART receiver and transmitter.
//   uart_state_t       : 3-bit FSM state encodings (s_PARITY is only used when
//                        the UART_RX_PARITY_EN build option is defined)
//   DATA_WIDTH         : payload bits per frame
//   calc_clks_per_bit(): system clocks per UART bit from clock and baud rate
package uart_pkg;

    typedef enum logic [2:0] {
        s_IDLE    = 3'd0,
        s_START   = 3'd1,
        s_DATA    = 3'd2,
        s_PARITY  = 3'd3,
        s_STOP    = 3'd4,
        s_CLEANUP = 3'd5
    } uart_state_t;

    localparam int DATA_WIDTH = 8;

    // Rounded to the nearest integer so a slightly fast or slow clock still
    // lands the sample point closest to the bit centre.
    function automatic int calc_clks_per_bit(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_sync_2ff.sv
// uart_sync_2ff -- two-flop synchroniser for an asynchronous, idle-high input.
//   clk   : destination clock, rising edge
//   rst_n : asynchronous active-low reset; both flops reset to 1 (idle level)
//   d     : asynchronous input
//   q     : synchronised output, two clocks behind d
module uart_sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Resetting to 1 keeps an idle-high line from looking like a start bit
    // straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx -- 8N1 UART receiver, LSB first, idle-high line.
//   i_Clock         : system clock, rising edge
//   i_Rst_n         : asynchronous active-low reset
//   i_Rx_Serial     : asynchronous serial line
//   o_Rx_DV         : one-cycle strobe, o_Rx_Byte holds a newly received byte
//   o_Rx_Byte       : last correctly framed byte, held until the next one
//   o_Rx_Active     : high from start-bit detect until return to idle
//   o_Rx_Frame_Err  : one-cycle strobe, stop bit sampled low
//   o_Rx_Parity_Err : one-cycle strobe, even-parity mismatch
// Build option: define UART_RX_PARITY_EN to expect an even-parity bit between
// the data and the stop bit; otherwise o_Rx_Parity_Err is constant 0.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic                  i_Clock,
    input  logic                  i_Rst_n,
    input  logic                  i_Rx_Serial,
    output logic                  o_Rx_DV,
    output logic [DATA_WIDTH-1:0] o_Rx_Byte,
    output logic                  o_Rx_Active,
    output logic                  o_Rx_Frame_Err,
    output logic                  o_Rx_Parity_Err
);

    localparam logic [7:0] HALF_COUNT = 8'((CLKS_PER_BIT - 1) / 2);
    localparam logic [7:0] LAST_COUNT = 8'(CLKS_PER_BIT - 1);

    uart_state_t           state;
    logic [7:0]            clk_count;
    logic [2:0]            bit_index;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  rx_s;

`ifdef UART_RX_PARITY_EN
    logic parity_bit;
    logic parity_err;
    assign o_Rx_Parity_Err = parity_err;
`else
    assign o_Rx_Parity_Err = 1'b0;
`endif

    uart_sync_2ff u_sync (
        .clk   (i_Clock),
        .rst_n (i_Rst_n),
        .d     (i_Rx_Serial),
        .q     (rx_s)
    );

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state          <= s_IDLE;
            clk_count      <= '0;
            bit_index      <= '0;
            shift_reg      <= '0;
            o_Rx_DV        <= 1'b0;
            o_Rx_Byte      <= '0;
            o_Rx_Active    <= 1'b0;
            o_Rx_Frame_Err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit     <= 1'b0;
            parity_err     <= 1'b0;
`endif
        end else begin
            // Strobes are single-cycle unless a state below raises them.
            o_Rx_DV        <= 1'b0;
            o_Rx_Frame_Err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err     <= 1'b0;
`endif
            case (state)
                s_IDLE: begin
                    clk_count   <= '0;
                    bit_index   <= '0;
                    o_Rx_Active <= 1'b0;
                    if (!rx_s) begin
                        state       <= s_START;
                        o_Rx_Active <= 1'b1;
                    end
                end

                // Re-check the line at the middle of the start bit; a high
                // level there means the falling edge was only a glitch.
                s_START: begin
                    if (clk_count == HALF_COUNT) begin
                        clk_count <= '0;
                        if (!rx_s) begin
                            state <= s_DATA;
                        end else begin
                            state       <= s_IDLE;
                            o_Rx_Active <= 1'b0;
                        end
                    end else begin
                        clk_count <= clk_count + 8'd1;
                    end
                end

                // Counting a full bit from the start-bit centre lands every
                // sample at the centre of its data bit.
                s_DATA: begin
                    if (clk_count == LAST_COUNT) begin
                        clk_count            <= '0;
                        shift_reg[bit_index] <= rx_s;
                        bit_index            <= bit_index + 3'd1;
                        if (bit_index == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= s_PARITY;
`else
                            state <= s_STOP;
`endif
                        end
                    end else begin
                        clk_count <= clk_count + 8'd1;
                    end
                end

`ifdef UART_RX_PARITY_EN
                s_PARITY: begin
                    if (clk_count == LAST_COUNT) begin
                        clk_count  <= '0;
                        parity_bit <= rx_s;
                        state      <= s_STOP;
                    end else begin
                        clk_count <= clk_count + 8'd1;
                    end
                end
`endif

                // A bad stop bit wins over a parity mismatch, and neither
                // touches the held output byte.
                s_STOP: begin
                    if (clk_count == LAST_COUNT) begin
                        clk_count <= '0;
                        state     <= s_CLEANUP;
                        if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                            if ((^shift_reg) == parity_bit) begin
                                o_Rx_Byte <= shift_reg;
                                o_Rx_DV   <= 1'b1;
                            end else begin
                                parity_err <= 1'b1;
                            end
`else
                            o_Rx_Byte <= shift_reg;
                            o_Rx_DV   <= 1'b1;
`endif
                        end else begin
                            o_Rx_Frame_Err <= 1'b1;
                        end
                    end else begin
                        clk_count <= clk_count + 8'd1;
                    end
                end

                s_CLEANUP: begin
                    o_Rx_Active <= 1'b0;
                    state       <= s_IDLE;
                end

                default: begin
                    state <= s_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- self-checking bench for uart_rx (CLKS_PER_BIT = 87).
// A behavioural serialiser drives frames; each frame pushes the strobe it
// should cause onto a queue, and a monitor pops and compares on every strobe.
// Build option: UART_RX_PARITY_EN adds a parity bit to every frame and a
// corrupted-parity test.
module tb_uart_rx;

    localparam int CPB = 87;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int FRAME_CYCLES = (10 + PAR_BITS) * CPB;
    localparam int NOM_LATENCY  = 2 + 1 + (CPB - 1) / 2 + (9 + PAR_BITS) * CPB;

    localparam int K_DV     = 0;
    localparam int K_FRAME  = 1;
    localparam int K_PARITY = 2;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_line;
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic       rx_active;
    logic       frame_err;
    logic       parity_err;

    int         tests_run = 0;
    int         tests_failed = 0;
    int         cycle = 0;
    int         last_fall = 0;
    int         last_dv = -100;
    logic [7:0] exp_hold = 8'h00;
    exp_t       exp_q[$];
    int         dv_times[$];

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clock         (clk),
        .i_Rst_n         (rst_n),
        .i_Rx_Serial     (rx_line),
        .o_Rx_DV         (rx_dv),
        .o_Rx_Byte       (rx_byte),
        .o_Rx_Active     (rx_active),
        .o_Rx_Frame_Err  (frame_err),
        .o_Rx_Parity_Err (parity_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     tag, actual, expected, cycle);
        end
    endtask

    // Drives one frame starting at a falling clock edge and returns on one;
    // gap is the number of idle-high cycles after the stop bit.
    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit,
                                 input logic bad_parity, input int gap);
        exp_t e;
        logic par_fault;
`ifdef UART_RX_PARITY_EN
        par_fault = bad_parity;
`else
        par_fault = 1'b0;
`endif
        if (!stop_bit) begin
            e.kind = K_FRAME;
            e.data = exp_hold;
        end else if (par_fault) begin
            e.kind = K_PARITY;
            e.data = exp_hold;
        end else begin
            e.kind   = K_DV;
            e.data   = data;
            exp_hold = data;
        end
        exp_q.push_back(e);

        rx_line   = 1'b0;
        last_fall = cycle;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_line = data[i];
            repeat (CPB) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx_line = (^data) ^ bad_parity;
        repeat (CPB) @(negedge clk);
`endif
        rx_line = stop_bit;
        repeat (CPB) @(negedge clk);
        rx_line = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    // Monitor: every strobe must match the head of the queue.
    always @(negedge clk) begin
        exp_t e;
        int   kind_seen;
        int   dev;
        if (rst_n) begin
            if (rx_dv || frame_err || parity_err) begin
                kind_seen = rx_dv ? K_DV : (frame_err ? K_FRAME : K_PARITY);
                checkOutput("strobe_count", 32'(rx_dv) + 32'(frame_err) + 32'(parity_err), 1);
                if (exp_q.size() == 0) begin
                    checkOutput("spurious_strobe", {29'd0, parity_err, frame_err, rx_dv}, 0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("strobe_kind", kind_seen, e.kind);
                    checkOutput("rx_byte", rx_byte, e.data);
                end
                if (rx_dv) begin
                    dev = cycle - last_fall - NOM_LATENCY;
                    checkOutput("latency", (dev < -1 || dev > 1) ? cycle - last_fall : NOM_LATENCY,
                                NOM_LATENCY);
                    dv_times.push_back(cycle);
                    last_dv = cycle;
                end
            end
            if (cycle == last_dv + 2) checkOutput("active_drop", rx_active, 0);
        end
    end

    initial begin
        #(10 * 200000);
        $display("[TB] FAIL watchdog: simulation did not finish, %0d tests run", tests_run);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         idx;
        int         period;
        logic [7:0] val;

        rst_n   = 1'b0;
        rx_line = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_dv", rx_dv, 0);
        checkOutput("reset_byte", rx_byte, 0);
        checkOutput("reset_active", rx_active, 0);
        checkOutput("reset_ferr", frame_err, 0);
        checkOutput("reset_perr", parity_err, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Plain frame
        applyStimulus(8'hA5, 1'b1, 1'b0, 2 * CPB);
        checkOutput("idle_after_a5", rx_active, 0);

        // Stop bit low: frame error, byte keeps 8'hA5
        applyStimulus(8'h3C, 1'b0, 1'b0, 3 * CPB);
        checkOutput("idle_after_ferr", rx_active, 0);

        // 20-cycle low glitch on an idle line, then a good frame
        rx_line = 1'b0;
        repeat (20) @(negedge clk);
        rx_line = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        checkOutput("glitch_idle", rx_active, 0);
        applyStimulus(8'h3C, 1'b1, 1'b0, 2 * CPB);

        // Back-to-back frames with no idle gap
        idx = dv_times.size();
        applyStimulus(8'h00, 1'b1, 1'b0, 0);
        applyStimulus(8'hFF, 1'b1, 1'b0, 0);
        applyStimulus(8'h55, 1'b1, 1'b0, 2 * CPB);
        checkOutput("b2b_count", dv_times.size() - idx, 3);
        if (dv_times.size() - idx == 3) begin
            for (int i = 1; i < 3; i++) begin
                period = dv_times[idx + i] - dv_times[idx + i - 1];
                checkOutput("b2b_period",
                            (period < FRAME_CYCLES - 2 || period > FRAME_CYCLES + 2) ? period : FRAME_CYCLES,
                            FRAME_CYCLES);
            end
        end

        // Reset during data bit 4 of 8'h81
        val     = 8'h81;
        rx_line = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx_line = val[i];
            repeat (CPB) @(negedge clk);
        end
        rx_line = val[4];
        repeat (40) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_dv", rx_dv, 0);
        checkOutput("midreset_byte", rx_byte, 0);
        checkOutput("midreset_active", rx_active, 0);
        checkOutput("midreset_ferr", frame_err, 0);
        checkOutput("midreset_perr", parity_err, 0);
        exp_hold = 8'h00;
        @(negedge clk);
        rx_line = 1'b1;
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        applyStimulus(8'h81, 1'b1, 1'b0, 2 * CPB);

`ifdef UART_RX_PARITY_EN
        // Corrupted parity: parity error strobe, no data strobe
        applyStimulus(8'h07, 1'b1, 1'b1, 2 * CPB);
`endif

        // Serialiser loopback: boundary values plus random bytes, no gaps
        applyStimulus(8'h01, 1'b1, 1'b0, 0);
        applyStimulus(8'h80, 1'b1, 1'b0, 0);
        applyStimulus(8'hFE, 1'b1, 1'b0, 0);
        applyStimulus(8'h7F, 1'b1, 1'b0, 0);
        for (int i = 0; i < 28; i++) begin
            val = 8'($urandom_range(0, 255));
            applyStimulus(val, 1'b1, 1'b0, 0);
        end
        repeat (4 * CPB) @(negedge clk);

        checkOutput("pending_expectations", exp_q.size(), 0);
        checkOutput("final_idle", rx_active, 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
